// File: rtl/parameter_pkg.sv
// Shared widths and the reservation-station entry type, plus the operand
// capture helper used for both dispatch bypass and CDB wakeup.
package parameter_pkg;

    localparam int PHY_W  = 6;
    localparam int DATA_W = 32;
    localparam int OP_W   = 8;
    localparam int ROB_W  = 6;

    localparam logic [PHY_W-1:0] PHY_ZERO = '0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  rob_idx;
        logic [PHY_W-1:0]  rd_tag;
        logic [PHY_W-1:0]  rs1_tag;
        logic              rs1_rdy;
        logic [DATA_W-1:0] rs1_val;
        logic [PHY_W-1:0]  rs2_tag;
        logic              rs2_rdy;
        logic [DATA_W-1:0] rs2_val;
    } rs_entry_t;

    // Port 0 is checked first so it wins when both broadcasts match.
    function automatic rs_entry_t rs_capture(
        input rs_entry_t         e,
        input logic              v0,
        input logic [PHY_W-1:0]  t0,
        input logic [DATA_W-1:0] d0,
        input logic              v1,
        input logic [PHY_W-1:0]  t1,
        input logic [DATA_W-1:0] d1
    );
        rs_entry_t r;
        r = e;
        if (!r.rs1_rdy) begin
            if (r.rs1_tag == PHY_ZERO) begin
                r.rs1_rdy = 1'b1;
                r.rs1_val = '0;
            end else if (v0 && t0 == r.rs1_tag) begin
                r.rs1_rdy = 1'b1;
                r.rs1_val = d0;
            end else if (v1 && t1 == r.rs1_tag) begin
                r.rs1_rdy = 1'b1;
                r.rs1_val = d1;
            end
        end
        if (!r.rs2_rdy) begin
            if (r.rs2_tag == PHY_ZERO) begin
                r.rs2_rdy = 1'b1;
                r.rs2_val = '0;
            end else if (v0 && t0 == r.rs2_tag) begin
                r.rs2_rdy = 1'b1;
                r.rs2_val = d0;
            end else if (v1 && t1 == r.rs2_tag) begin
                r.rs2_rdy = 1'b1;
                r.rs2_val = d1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the reservation station and oldest-ready one-hot pick.
// age_reg[i][j] = 1 means entry i is older than entry j.
module rs_age_select #(
    parameter int N      = 8,
    parameter int SLOT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [N-1:0]      valid,
    input  logic [N-1:0]      cand,
    input  logic              sel_en,
    input  logic              disp_we_0,
    input  logic [SLOT_W-1:0] disp_slot_0,
    input  logic              disp_we_1,
    input  logic [SLOT_W-1:0] disp_slot_1,
    output logic [N-1:0]      grant
);

    logic [N-1:0] age_reg  [N];
    logic [N-1:0] age_next [N];
    logic [N-1:0] issue_clr;
    logic [N-1:0] older_valid;

    assign issue_clr   = sel_en ? grant : '0;
    assign older_valid = valid & ~issue_clr;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pick
            logic [N-1:0] older_cand;
            for (gj = 0; gj < N; gj++) begin : g_older
                assign older_cand[gj] = cand[gj] & age_reg[gj][gi];
            end
            assign grant[gi] = cand[gi] & ~(|older_cand);
        end
    endgenerate

    // Rows of new entries clear (younger than all); columns take the surviving
    // valid set. Lane 0 beats lane 1 when both dispatch together.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                age_next[i][j] = age_reg[i][j] && !issue_clr[i] && !issue_clr[j];
                if (disp_we_0 && disp_slot_0 == SLOT_W'(i))
                    age_next[i][j] = 1'b0;
                if (disp_we_1 && disp_slot_1 == SLOT_W'(i))
                    age_next[i][j] = 1'b0;
                if (disp_we_0 && disp_slot_0 == SLOT_W'(j))
                    age_next[i][j] = older_valid[i];
                if (disp_we_1 && disp_slot_1 == SLOT_W'(j))
                    age_next[i][j] = older_valid[i] || (disp_we_0 && disp_slot_0 == SLOT_W'(i));
                if (i == j)
                    age_next[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || flush)
                age_reg[i] <= '0;
            else
                age_reg[i] <= age_next[i];
        end
    end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation-station entry array: dual dispatch, two-port CDB wakeup,
// oldest-ready issue with a registered output and a slot-return pulse.
module rs_issue_queue
    import parameter_pkg::*;
#(
    parameter int NUM_RS_ENTRIES = 8,
    parameter int TYPE           = 0,
    parameter int SLOT_W         = $clog2(NUM_RS_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid_0,
    input  logic              disp_valid_1,
    input  logic [SLOT_W-1:0] disp_slot_0,
    input  logic [SLOT_W-1:0] disp_slot_1,
    input  rs_entry_t         disp_entry_0,
    input  rs_entry_t         disp_entry_1,
    input  logic              cdb_valid_0,
    input  logic              cdb_valid_1,
    input  logic [PHY_W-1:0]  cdb_tag_0,
    input  logic [PHY_W-1:0]  cdb_tag_1,
    input  logic [DATA_W-1:0] cdb_data_0,
    input  logic [DATA_W-1:0] cdb_data_1,
    input  logic              issue_ready,
    output logic              issue_valid,
    output rs_entry_t         issue_entry,
    output logic              issue_free_valid,
    output logic [SLOT_W:0]   issue_free
);

    localparam int N = NUM_RS_ENTRIES;

    logic [N-1:0]      valid_reg;
    logic [N-1:0]      valid_next;
    logic [N-1:0]      cand;
    logic [N-1:0]      grant;
    logic [N-1:0]      issue_clr;
    rs_entry_t         entry_reg  [N];
    rs_entry_t         entry_next [N];
    logic              sel_en;
    logic              any_grant;
    logic [SLOT_W-1:0] win_idx;

    logic              issue_valid_reg;
    rs_entry_t         issue_entry_reg;
    logic              issue_free_valid_reg;
    logic [SLOT_W:0]   issue_free_reg;

    assign sel_en    = !issue_valid_reg || issue_ready;
    assign any_grant = |grant;
    assign issue_clr = sel_en ? grant : '0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            logic      hit_0;
            logic      hit_1;
            rs_entry_t src;
            assign hit_0 = disp_valid_0 && (disp_slot_0 == SLOT_W'(gi));
            assign hit_1 = disp_valid_1 && (disp_slot_1 == SLOT_W'(gi));
            assign src   = hit_0 ? disp_entry_0 : (hit_1 ? disp_entry_1 : entry_reg[gi]);
            // Same capture path serves dispatch bypass and wakeup of held entries.
            assign entry_next[gi] = rs_capture(src, cdb_valid_0, cdb_tag_0, cdb_data_0,
                                               cdb_valid_1, cdb_tag_1, cdb_data_1);
            assign valid_next[gi] = hit_0 || hit_1 || (valid_reg[gi] && !issue_clr[gi]);
            assign cand[gi] = valid_reg[gi] && entry_reg[gi].rs1_rdy && entry_reg[gi].rs2_rdy;
        end
    endgenerate

    rs_age_select #(
        .N      (N),
        .SLOT_W (SLOT_W)
    ) u_age_select (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .valid       (valid_reg),
        .cand        (cand),
        .sel_en      (sel_en),
        .disp_we_0   (disp_valid_0),
        .disp_slot_0 (disp_slot_0),
        .disp_we_1   (disp_valid_1),
        .disp_slot_1 (disp_slot_1),
        .grant       (grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i])
                win_idx = win_idx | SLOT_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            entry_reg[i] <= entry_next[i];
        if (rst || flush) begin
            valid_reg            <= '0;
            issue_valid_reg      <= 1'b0;
            issue_entry_reg      <= '0;
            issue_free_valid_reg <= 1'b0;
            issue_free_reg       <= '0;
        end else begin
            valid_reg            <= valid_next;
            issue_free_valid_reg <= sel_en && any_grant;
            if (sel_en) begin
                issue_valid_reg <= any_grant;
                if (any_grant) begin
                    issue_entry_reg <= entry_reg[win_idx];
                    issue_free_reg  <= {1'b0, win_idx};
                end
            end
        end
    end

    assign issue_valid      = issue_valid_reg;
    assign issue_entry      = issue_entry_reg;
    assign issue_free_valid = issue_free_valid_reg;
    assign issue_free       = issue_free_reg;

    // Allocator contract violations; flush cycles are exempt.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (TYPE >= 0 && TYPE <= 2);
            assert (!(disp_valid_0 && valid_reg[disp_slot_0]));
            assert (!(disp_valid_1 && valid_reg[disp_slot_1]));
            assert (!(disp_valid_0 && disp_valid_1 && disp_slot_0 == disp_slot_1));
            assert (!((disp_valid_0 || disp_valid_1) && (&valid_reg)));
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Scoreboard bench for rs_issue_queue: expected issues are queued at dispatch
// with their exact issue cycle and compared when the free pulse appears.
`timescale 1ns/1ps
module tb_rs_issue_queue;
    import parameter_pkg::*;

    localparam int N  = 8;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              disp_valid_0, disp_valid_1;
    logic [SW-1:0]     disp_slot_0, disp_slot_1;
    rs_entry_t         disp_entry_0, disp_entry_1;
    logic              cdb_valid_0, cdb_valid_1;
    logic [PHY_W-1:0]  cdb_tag_0, cdb_tag_1;
    logic [DATA_W-1:0] cdb_data_0, cdb_data_1;
    logic              issue_ready;
    logic              issue_valid;
    rs_entry_t         issue_entry;
    logic              issue_free_valid;
    logic [SW:0]       issue_free;

    rs_issue_queue #(.NUM_RS_ENTRIES(N), .TYPE(0)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .disp_valid_0     (disp_valid_0),
        .disp_valid_1     (disp_valid_1),
        .disp_slot_0      (disp_slot_0),
        .disp_slot_1      (disp_slot_1),
        .disp_entry_0     (disp_entry_0),
        .disp_entry_1     (disp_entry_1),
        .cdb_valid_0      (cdb_valid_0),
        .cdb_valid_1      (cdb_valid_1),
        .cdb_tag_0        (cdb_tag_0),
        .cdb_tag_1        (cdb_tag_1),
        .cdb_data_0       (cdb_data_0),
        .cdb_data_1       (cdb_data_1),
        .issue_ready      (issue_ready),
        .issue_valid      (issue_valid),
        .issue_entry      (issue_entry),
        .issue_free_valid (issue_free_valid),
        .issue_free       (issue_free)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SW-1:0] slot;
        rs_entry_t     e;
        int            at;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rs_entry_t mk(input logic [7:0] op,
                                     input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                                     input logic [5:0] t2, input logic r2, input logic [31:0] v2);
        rs_entry_t e;
        e.op      = op;
        e.rob_idx = op[5:0];
        e.rd_tag  = 6'(op + 8'd3);
        e.rs1_tag = t1;
        e.rs1_rdy = r1;
        e.rs1_val = v1;
        e.rs2_tag = t2;
        e.rs2_rdy = r2;
        e.rs2_val = v2;
        return e;
    endfunction

    // One line per observed issue; every free pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && issue_free_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_free", 128'(issue_free_valid), 128'(0));
            end else begin
                x = sb.pop_front();
                $display("issue slot=%0d op=%0h cyc=%0d", issue_free, issue_entry.op, cyc);
                check_eq("issue_valid", 128'(issue_valid), 128'(1));
                check_eq("issue_free", 128'(issue_free), 128'(x.slot));
                check_eq("issue_entry", 128'(issue_entry), 128'(x.e));
                check_eq("issue_cycle", 128'(cyc), 128'(x.at));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_inputs();
        flush        = 1'b0;
        disp_valid_0 = 1'b0;
        disp_valid_1 = 1'b0;
        disp_slot_0  = '0;
        disp_slot_1  = '0;
        disp_entry_0 = '0;
        disp_entry_1 = '0;
        cdb_valid_0  = 1'b0;
        cdb_valid_1  = 1'b0;
        cdb_tag_0    = '0;
        cdb_tag_1    = '0;
        cdb_data_0   = '0;
        cdb_data_1   = '0;
    endtask

    task automatic drive_disp(input int lane, input logic [SW-1:0] slot, input rs_entry_t e);
        if (lane == 0) begin
            disp_valid_0 = 1'b1;
            disp_slot_0  = slot;
            disp_entry_0 = e;
        end else begin
            disp_valid_1 = 1'b1;
            disp_slot_1  = slot;
            disp_entry_1 = e;
        end
    endtask

    task automatic expect_issue(input logic [SW-1:0] slot, input rs_entry_t e, input int at);
        exp_t x;
        x.slot = slot;
        x.e    = e;
        x.at   = at;
        sb.push_back(x);
    endtask

    initial begin
        int k;
        rs_entry_t e, ea, eb, ec;

        clear_inputs();
        issue_ready = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        @(negedge clk);
        check_eq("rst_issue_valid", 128'(issue_valid), 128'(0));
        check_eq("rst_free_valid", 128'(issue_free_valid), 128'(0));
        check_eq("rst_free", 128'(issue_free), 128'(0));
        check_eq("rst_entry", 128'(issue_entry), 128'(0));
        tick();

        // Single ready op into slot 3: two-cycle latency.
        k = cyc;
        e = mk(8'h11, 6'd1, 1'b1, 32'hA1, 6'd2, 1'b1, 32'hB1);
        drive_disp(0, 3'd3, e);
        expect_issue(3'd3, e, k + 2);
        tick(); clear_inputs(); idle(4);

        // Dual dispatch: lane 0 (slot 5) is older than lane 1 (slot 2).
        k = cyc;
        ea = mk(8'h25, 6'd3, 1'b1, 32'h5, 6'd4, 1'b1, 32'h55);
        eb = mk(8'h22, 6'd5, 1'b1, 32'h2, 6'd6, 1'b1, 32'h22);
        drive_disp(0, 3'd5, ea);
        drive_disp(1, 3'd2, eb);
        expect_issue(3'd5, ea, k + 2);
        expect_issue(3'd2, eb, k + 3);
        tick(); clear_inputs(); idle(4);

        // Wakeup via CDB port 1 two cycles after dispatch; unrelated tag first.
        k = cyc;
        e = mk(8'h33, 6'd17, 1'b0, 32'h0, 6'd7, 1'b1, 32'h77);
        ea = e;
        ea.rs1_rdy = 1'b1;
        ea.rs1_val = 32'hDEAD;
        drive_disp(0, 3'd4, e);
        expect_issue(3'd4, ea, k + 4);
        tick(); clear_inputs();
        cdb_valid_0 = 1'b1; cdb_tag_0 = 6'd18; cdb_data_0 = 32'hBAD;
        tick(); clear_inputs();
        cdb_valid_1 = 1'b1; cdb_tag_1 = 6'd17; cdb_data_1 = 32'hDEAD;
        tick(); clear_inputs(); idle(4);

        // Dispatch bypass from CDB port 0 in the same cycle.
        k = cyc;
        e = mk(8'h44, 6'd8, 1'b1, 32'h88, 6'd9, 1'b0, 32'h0);
        ea = e;
        ea.rs2_rdy = 1'b1;
        ea.rs2_val = 32'h1234;
        drive_disp(0, 3'd1, e);
        cdb_valid_0 = 1'b1; cdb_tag_0 = 6'd9; cdb_data_0 = 32'h1234;
        expect_issue(3'd1, ea, k + 2);
        tick(); clear_inputs(); idle(4);

        // Lane 1 alone, PHY_ZERO source forced ready with value 0.
        k = cyc;
        e = mk(8'h46, 6'd0, 1'b0, 32'h55, 6'd10, 1'b1, 32'hAA);
        ea = e;
        ea.rs1_rdy = 1'b1;
        ea.rs1_val = 32'h0;
        drive_disp(1, 3'd6, e);
        expect_issue(3'd6, ea, k + 2);
        tick(); clear_inputs(); idle(4);

        // Stall: three ready entries, consumer blocked for four edges.
        k = cyc;
        issue_ready = 1'b0;
        ea = mk(8'h50, 6'd11, 1'b1, 32'h50, 6'd12, 1'b1, 32'h500);
        eb = mk(8'h51, 6'd13, 1'b1, 32'h51, 6'd14, 1'b1, 32'h501);
        ec = mk(8'h52, 6'd15, 1'b1, 32'h52, 6'd16, 1'b1, 32'h502);
        drive_disp(0, 3'd0, ea);
        drive_disp(1, 3'd1, eb);
        expect_issue(3'd0, ea, k + 2);
        expect_issue(3'd1, eb, k + 7);
        expect_issue(3'd4, ec, k + 8);
        tick(); clear_inputs();
        drive_disp(0, 3'd4, ec);
        tick(); clear_inputs();
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 128'(issue_valid), 128'(1));
            check_eq("stall_entry", 128'(issue_entry), 128'(ea));
            check_eq("stall_free_valid", 128'(issue_free_valid), 128'(0));
            if (i < 3) tick();
        end
        issue_ready = 1'b1;
        tick(); idle(5);

        // Fill all slots with waiting ops, then flush alongside a dispatch and CDB.
        for (int p = 0; p < 4; p++) begin
            drive_disp(0, 3'(2 * p), mk(8'(8'h60 + 2 * p), 6'd20, 1'b0, 32'h0, 6'd21, 1'b1, 32'h1));
            drive_disp(1, 3'(2 * p + 1), mk(8'(8'h61 + 2 * p), 6'd20, 1'b0, 32'h0, 6'd21, 1'b1, 32'h1));
            tick();
        end
        clear_inputs();
        flush = 1'b1;
        drive_disp(0, 3'd0, mk(8'h70, 6'd22, 1'b1, 32'h7, 6'd23, 1'b1, 32'h8));
        cdb_valid_0 = 1'b1; cdb_tag_0 = 6'd20; cdb_data_0 = 32'h77;
        tick(); clear_inputs();
        @(negedge clk);
        check_eq("flush_issue_valid", 128'(issue_valid), 128'(0));
        check_eq("flush_free_valid", 128'(issue_free_valid), 128'(0));
        check_eq("flush_free", 128'(issue_free), 128'(0));
        check_eq("flush_entry", 128'(issue_entry), 128'(0));
        tick();
        cdb_valid_1 = 1'b1; cdb_tag_1 = 6'd20; cdb_data_1 = 32'h99;
        tick(); clear_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("flush_no_issue", 128'(issue_valid), 128'(0));
            tick();
        end

        // Station usable again after flush.
        k = cyc;
        e = mk(8'h7F, 6'd24, 1'b1, 32'hF0, 6'd25, 1'b1, 32'hF1);
        drive_disp(0, 3'd7, e);
        expect_issue(3'd7, e, k + 2);
        tick(); clear_inputs(); idle(5);

        check_eq("sb_empty", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_issue_queue.md
# rs_issue_queue

Reservation-station entry array for one execution cluster (ALU, LSU or BRU, selected by `TYPE`). It sits directly downstream of the per-station slot allocator. Each cycle it:
- accepts up to two dispatched micro-ops into the slot indices handed out by the allocator;
- captures operands from two CDB broadcast ports;
- issues the oldest fully-ready entry to the functional unit;
- returns that entry's slot index to the allocator through `issue_free_valid`/`issue_free`.

## Interface
Parameters:
- `NUM_RS_ENTRIES`, 8, entry count; power of two.
- `TYPE`, 0, cluster tag (0 ALU, 1 LOAD/STORE, 2 BRANCH); debug/naming only, no functional effect.
- `SLOT_W`, `$clog2(NUM_RS_ENTRIES)`, slot index width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `flush`  in  1  pipeline flush; empties the station.
- `disp_valid_0`, `disp_valid_1`  in  1 each  dispatch lane strobes.
- `disp_slot_0`, `disp_slot_1`  in  SLOT_W each  target slot; equals the allocator's `free_0`/`free_1` in the same cycle.
- `disp_entry_0`, `disp_entry_1`  in  `rs_entry_t` each  micro-op payload. Fields: `op`, `rob_idx`, `rd_tag`, `rs1_tag/rdy/val`, `rs2_tag/rdy/val`.
- `cdb_valid_0`, `cdb_valid_1`  in  1 each  result broadcast strobes.
- `cdb_tag_0`, `cdb_tag_1`  in  PHY_W each  physical destination tags.
- `cdb_data_0`, `cdb_data_1`  in  DATA_W each  result values.
- `issue_ready`  in  1  functional unit accepts `issue_entry` this cycle.
- `issue_valid`  out  1  `issue_entry` holds a valid micro-op.
- `issue_entry`  out  `rs_entry_t`  issued micro-op with both operand values filled.
- `issue_free_valid`  out  1  one-cycle pulse returning one slot to the allocator.
- `issue_free`  out  SLOT_W+1  returned slot index, zero-extended to the allocator's port width.

## Operation
Per-entry state:
- `valid`, payload, and an N×N age matrix (`age[i][j]=1` means entry i is older than entry j).

Dispatch:
- Lane k writes `disp_entry_k` into `disp_slot_k` and sets `valid`.
- The new entry is younger than every currently valid entry.
- When both lanes dispatch in the same cycle, lane 0 is older than lane 1.
- Lane 1 may be valid while lane 0 is not.

Dispatch bypass:
- An operand with `rdy=0` whose tag matches a same-cycle valid CDB tag is written as ready with the CDB data.
- Tag 0 (PHY_ZERO) is always written ready with value 0.

Wakeup:
- Each valid entry with an unready operand compares its tag against both CDB ports.
- On a match, the entry sets `rdy` and latches the data. If both ports match, port 0 wins; identical data is expected in that case.

Select:
- The candidate set is entries with `valid` and both operands ready.
- The winner is the candidate with no older candidate.
- Selection is enabled when `!issue_valid || issue_ready`.

Issue:
- On an enabled select, the winner is loaded into the output register and its `valid` is cleared.
- In the same edge, `issue_free_valid` is set to 1 and `issue_free` to the winner's slot.
- If no candidate exists, `issue_valid` falls to 0 when the held op is accepted.
- At most one issue and one slot return per cycle.

Flush:
- Clears all `valid` bits, the age matrix, `issue_valid` and `issue_free_valid`.
- Takes priority over same-cycle dispatch, CDB and select.
- No slots are returned; the allocator reinitialises itself on flush.

Reset:
- Same effect as flush. `issue_entry` = '0, `issue_free` = 0, all outputs low.

Illegal inputs, flagged by simulation assertions:
- dispatch to a slot that is already valid;
- both lanes targeting the same slot;
- dispatch while all entries are valid.

## Timing
- Dispatch in cycle t → entry present at edge t+1 → earliest select in cycle t+1 → `issue_valid` in cycle t+2.
- CDB in cycle t (dispatch bypass or wakeup) → operand ready after edge t+1 → selectable in cycle t+1. There is no same-cycle CDB-to-select path.
- `issue_free_valid` pulses for exactly one cycle, aligned with the first cycle `issue_valid` presents that op.
- A slot freed at edge t+1 may be re-dispatched by the allocator from cycle t+2 onward.
- Stall (`issue_valid && !issue_ready`): `issue_entry` is held stable, no select, no free pulse, wakeup continues.
- Back-to-back issue runs at one per cycle while `issue_ready` stays high.

## Structure
- `parameter_pkg` gains:
  - `rs_entry_t`;
  - `PHY_W` (6) and `DATA_W` (32);
  - `PHY_ZERO`.
- Sub-module `rs_age_select`:
  - contains the age matrix, its update on dispatch, issue and flush, and the oldest-ready one-hot pick;
  - `rs_issue_queue` encodes the one-hot pick to a slot index.

## Test plan
- Reset, then dispatch one op to slot 3 with both operands ready → `issue_valid`=1 two cycles later with slot 3's payload, `issue_free_valid`=1 with `issue_free`=3.
- Dual dispatch into slots 5 (lane 0) and 2 (lane 1), both ready → slot 5 issues first, slot 2 next cycle; free pulses return 5 then 2.
- Dispatch op with `rs1_tag`=17 not ready; `cdb_valid_1`, tag 17, data 0xDEAD two cycles later → issues with `rs1_val`=0xDEAD no earlier than one cycle after the CDB.
- Same-cycle dispatch with `rs2_tag`=9 and `cdb_tag_0`=9 → captured at dispatch, issues at the minimum two-cycle latency.
- Three ready entries with `issue_ready`=0 for 4 cycles → `issue_entry` stable, no free pulses; after release, the remaining two issue oldest-first on consecutive cycles.
- Fill all 8 slots, assert `flush` along with a dispatch and a CDB → next cycle all outputs 0, no free pulse, no later issue of the flushed ops.
